// File: rtl/mmio_bus_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : mmio_bus_arbiter                                                 |
// | Brief   : Two-requester round-robin arbiter for the MMIO peripheral bus,   |
// |           one outstanding transaction, with a peripheral ack timeout.      |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module mmio_bus_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  // requester 0: CPU data port
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_ack,
  output logic              m0_err,
  // requester 1: UART debug/loader engine
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_ack,
  output logic              m1_err,
  // peripheral side
  output logic              s_req,
  output logic              s_we,
  output logic [ADDR_W-1:0] s_addr,
  output logic [DATA_W-1:0] s_wdata,
  input  logic [DATA_W-1:0] s_rdata,
  input  logic              s_ack,
  // status
  output logic              owner,
  output logic              busy
);

  // Counter only ever holds 0..MAX_WAIT-1; the expiry is decided on the last value.
  localparam int                 c_cnt_w    = $clog2(MAX_WAIT + 1);
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(MAX_WAIT - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic                r_owner;
  logic                r_last_owner;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_err;
  logic [c_cnt_w-1:0]  r_cnt;
  logic                w_any_req;
  logic                w_grant;
  logic                w_expire;

  assign w_any_req = m0_req | m1_req;
  // Requester 1 wins when alone, or on a tie when requester 0 was served last.
  assign w_grant   = m1_req & (~m0_req | ~r_last_owner);
  assign w_expire  = (r_cnt == c_cnt_last);

  // State register; async reset discards any transaction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and state-decoded outputs; acks and s_req fall straight off the state register.
  always_comb begin
    w_state_next = r_state;
    s_req        = 1'b0;
    busy         = 1'b1;
    m0_ack       = 1'b0;
    m1_ack       = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (w_any_req) begin
          w_state_next = S_BUSY;
        end
      end
      S_BUSY: begin
        s_req = 1'b1;
        if (s_ack || w_expire) begin
          w_state_next = S_RESP;
        end
      end
      S_RESP: begin
        m0_ack       = ~r_owner;
        m1_ack       = r_owner;
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Grant-time latching of the winner's command, wait counting, and response capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_owner      <= 1'b0;
      r_last_owner <= 1'b1;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_rdata      <= '0;
      r_err        <= 1'b0;
      r_cnt        <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_owner      <= w_grant;
            r_last_owner <= w_grant;
            r_we         <= w_grant ? m1_we    : m0_we;
            r_addr       <= w_grant ? m1_addr  : m0_addr;
            r_wdata      <= w_grant ? m1_wdata : m0_wdata;
            r_cnt        <= '0;
          end
        end
        S_BUSY: begin
          // An ack arriving on the expiry cycle still counts as a normal completion.
          if (s_ack) begin
            r_rdata <= r_we ? '0 : s_rdata;
            r_err   <= 1'b0;
          end else if (w_expire) begin
            r_rdata <= '0;
            r_err   <= 1'b1;
          end else begin
            r_cnt <= r_cnt + c_cnt_one;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Response data is shared; each requester only treats it as valid alongside its own ack.
  assign m0_rdata = r_rdata;
  assign m1_rdata = r_rdata;
  assign m0_err   = r_err;
  assign m1_err   = r_err;
  assign s_we     = r_we;
  assign s_addr   = r_addr;
  assign s_wdata  = r_wdata;
  assign owner    = r_owner;

endmodule
`default_nettype wire

// File: tb/tb_mmio_bus_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_mmio_bus_arbiter                                              |
// | Brief   : Self-checking bench for mmio_bus_arbiter with a delay-programmable|
// |           peripheral and a transaction-level reference model.              |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_mmio_bus_arbiter;

  localparam int MW = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        m0_req = 1'b0, m0_we = 1'b0;
  logic [31:0] m0_addr = '0, m0_wdata = '0, m0_rdata;
  logic        m0_ack, m0_err;
  logic        m1_req = 1'b0, m1_we = 1'b0;
  logic [31:0] m1_addr = '0, m1_wdata = '0, m1_rdata;
  logic        m1_ack, m1_err;
  logic        s_req, s_we;
  logic [31:0] s_addr, s_wdata;
  logic [31:0] s_rdata = '0;
  logic        s_ack = 1'b0;
  logic        owner, busy;

  int checks = 0;
  int failures = 0;

  // peripheral model controls: delay<0 means never ack
  int          slv_delay = 0;
  logic [31:0] slv_data = '0;
  bit          slv_noise = 1'b0;
  int          slv_n = 0;

  // reference model state
  bit          mdl_last = 1'b1;
  int          exp_acks = 0;
  int          ack0_cnt = 0;
  int          ack1_cnt = 0;
  logic        rw[2];
  logic [31:0] ra[2];
  logic [31:0] rwd[2];

  always #5 clk = ~clk;

  mmio_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(MW)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_rdata(m0_rdata), .m0_ack(m0_ack), .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_rdata(m1_rdata), .m1_ack(m1_ack), .m1_err(m1_err),
    .s_req(s_req), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_rdata(s_rdata), .s_ack(s_ack), .owner(owner), .busy(busy)
  );

  // Peripheral: acks on the (slv_delay+1)-th cycle it sees s_req; optional stray acks when idle.
  initial begin : slave
    forever begin
      @(posedge clk); #2;
      if (s_req) begin
        s_ack   = (slv_delay >= 0) && (slv_n == slv_delay);
        s_rdata = s_ack ? slv_data : $urandom;
        slv_n++;
      end else begin
        slv_n   = 0;
        s_ack   = slv_noise ? 1'($urandom_range(0, 1)) : 1'b0;
        s_rdata = $urandom;
      end
    end
  end

  // Count every ack pulse to catch lost or duplicated completions.
  always @(negedge clk) begin
    if (m0_ack) ack0_cnt++;
    if (m1_ack) ack1_cnt++;
  end

  function automatic int exp_busy(input int d);
    return (d < 0 || d >= MW) ? MW : d + 1;
  endfunction

  function automatic logic exp_err(input int d);
    return (d < 0 || d >= MW);
  endfunction

  task automatic set_req(input int p, input logic we, input logic [31:0] a, input logic [31:0] d);
    rw[p] = we; ra[p] = a; rwd[p] = d;
    if (p == 0) begin m0_req = 1'b1; m0_we = we; m0_addr = a; m0_wdata = d; end
    else        begin m1_req = 1'b1; m1_we = we; m1_addr = a; m1_wdata = d; end
  endtask

  task automatic drop_req(input int p);
    @(posedge clk); #1;
    if (p == 0) m0_req = 1'b0;
    else if (p == 1) m1_req = 1'b0;
    else begin m0_req = 1'b0; m1_req = 1'b0; end
  endtask

  // Observe one transaction: port (-1 none, 2 both), cycles from request to ack, BUSY cycles.
  task automatic wait_ack(output int port, output logic [31:0] rd, output logic er,
                          output int cyc, output int bc, output logic swe,
                          output logic [31:0] sa, output logic [31:0] sd, output logic own);
    port = -1; rd = '0; er = 1'b0; cyc = 0; bc = 0; swe = 1'b0; sa = '0; sd = '0; own = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      cyc++;
      if (s_req) begin
        if (bc == 0) begin swe = s_we; sa = s_addr; sd = s_wdata; end
        bc++;
      end
      if (m0_ack || m1_ack) begin
        port = (m0_ack && m1_ack) ? 2 : (m1_ack ? 1 : 0);
        rd   = m1_ack ? m1_rdata : m0_rdata;
        er   = m1_ack ? m1_err : m0_err;
        own  = owner;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({s_req, busy, m0_ack, m1_ack, owner, s_we} !== 6'b0) begin
      failures++; $display("FAIL reset_ctrl got=%b exp=000000", {s_req, busy, m0_ack, m1_ack, owner, s_we});
    end
    checks++;
    if ({m0_err, m1_err} !== 2'b0) begin
      failures++; $display("FAIL reset_err got=%b exp=00", {m0_err, m1_err});
    end
    checks++;
    if ({s_addr, s_wdata} !== 64'h0) begin
      failures++; $display("FAIL reset_bus got=%h exp=0", {s_addr, s_wdata});
    end
    checks++;
    if ({m0_rdata, m1_rdata} !== 64'h0) begin
      failures++; $display("FAIL reset_rdata got=%h exp=0", {m0_rdata, m1_rdata});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    mdl_last = 1'b1;
  endtask

  task automatic test_write_m0();
    int port, cyc, bc; logic [31:0] rd, sa, sd; logic er, swe, own;
    slv_delay = 0;
    @(posedge clk); #1;
    set_req(0, 1'b1, 32'h0000_7F00, 32'h0000_A5A5);
    wait_ack(port, rd, er, cyc, bc, swe, sa, sd, own);
    checks++;
    if (port !== 0) begin failures++; $display("FAIL wr_port got=%0d exp=0", port); end
    checks++;
    if (cyc !== 3) begin failures++; $display("FAIL wr_latency got=%0d exp=3", cyc); end
    checks++;
    if ({swe, sa, sd} !== {1'b1, 32'h7F00, 32'hA5A5}) begin
      failures++; $display("FAIL wr_bus got=%b/%h/%h exp=1/00007f00/0000a5a5", swe, sa, sd);
    end
    checks++;
    if ({er, rd, own} !== {1'b0, 32'h0, 1'b0}) begin
      failures++; $display("FAIL wr_resp got=err%b rd%h own%b exp=err0 rd0 own0", er, rd, own);
    end
    drop_req(0);
    mdl_last = 1'b0; exp_acks++;
    @(negedge clk);
    checks++;
    if (m0_ack !== 1'b0) begin failures++; $display("FAIL wr_single_pulse got=%b exp=0", m0_ack); end
  endtask

  task automatic test_read_m1();
    int port, cyc, bc, a0; logic [31:0] rd, sa, sd; logic er, swe, own;
    slv_delay = 3; slv_data = 32'h0000_00FF;
    a0 = ack0_cnt;
    @(posedge clk); #1;
    set_req(1, 1'b0, 32'h0000_7F10, 32'h0);
    wait_ack(port, rd, er, cyc, bc, swe, sa, sd, own);
    checks++;
    if (port !== 1) begin failures++; $display("FAIL rd_port got=%0d exp=1", port); end
    checks++;
    if ({rd, er} !== {32'h00FF, 1'b0}) begin
      failures++; $display("FAIL rd_data got=%h err%b exp=000000ff err0", rd, er);
    end
    checks++;
    if (bc !== 4 || cyc !== 6) begin
      failures++; $display("FAIL rd_timing got=busy%0d cyc%0d exp=busy4 cyc6", bc, cyc);
    end
    drop_req(1);
    mdl_last = 1'b1; exp_acks++;
    checks++;
    if (ack0_cnt !== a0) begin failures++; $display("FAIL rd_m0_quiet got=%0d exp=%0d", ack0_cnt, a0); end
  endtask

  task automatic test_round_robin();
    int port, cyc, bc, p, pend; logic [31:0] rd, sa, sd; logic er, swe, own;
    for (int r = 0; r < 4; r++) begin
      @(posedge clk); #1;
      set_req(0, 1'($urandom_range(0, 1)), $urandom, $urandom);
      set_req(1, 1'($urandom_range(0, 1)), $urandom, $urandom);
      pend = 3;
      for (int k = 0; k < 2; k++) begin
        p = (pend == 3) ? int'(!mdl_last) : (pend == 2 ? 1 : 0);
        slv_delay = $urandom_range(0, 3); slv_data = $urandom;
        wait_ack(port, rd, er, cyc, bc, swe, sa, sd, own);
        checks++;
        if (port !== p || own !== p[0]) begin
          failures++; $display("FAIL rr_grant r%0d k%0d got=port%0d own%b exp=%0d", r, k, port, own, p);
        end
        checks++;
        if ({swe, sa, sd} !== {rw[p], ra[p], rwd[p]}) begin
          failures++; $display("FAIL rr_bus r%0d k%0d got=%h exp=%h", r, k, sa, ra[p]);
        end
        checks++;
        if (cyc !== 2 + exp_busy(slv_delay)) begin
          failures++; $display("FAIL rr_latency r%0d k%0d got=%0d exp=%0d", r, k, cyc, 2 + exp_busy(slv_delay));
        end
        drop_req(p);
        mdl_last = p[0]; pend[p] = 1'b0; exp_acks++;
      end
    end
  endtask

  task automatic test_timeout();
    int port, cyc, bc; logic [31:0] rd, sa, sd; logic er, swe, own;
    slv_delay = -1;
    @(posedge clk); #1;
    set_req(0, 1'b0, 32'h0000_7F20, 32'h0);
    wait_ack(port, rd, er, cyc, bc, swe, sa, sd, own);
    checks++;
    if (port !== 0) begin failures++; $display("FAIL to_port got=%0d exp=0", port); end
    checks++;
    if ({er, rd} !== {1'b1, 32'h0}) begin
      failures++; $display("FAIL to_resp got=err%b rd%h exp=err1 rd0", er, rd);
    end
    checks++;
    if (bc !== MW || cyc !== MW + 2) begin
      failures++; $display("FAIL to_timing got=busy%0d cyc%0d exp=busy%0d cyc%0d", bc, cyc, MW, MW + 2);
    end
    drop_req(0);
    mdl_last = 1'b0; exp_acks++;
    slv_delay = 0; slv_data = 32'h0000_5A5A;
    @(posedge clk); #1;
    set_req(0, 1'b0, 32'h0000_7F24, 32'h0);
    wait_ack(port, rd, er, cyc, bc, swe, sa, sd, own);
    checks++;
    if (port !== 0 || cyc !== 3 || {er, rd} !== {1'b0, 32'h5A5A}) begin
      failures++; $display("FAIL to_recover got=port%0d cyc%0d err%b rd%h exp=port0 cyc3 err0 rd00005a5a", port, cyc, er, rd);
    end
    drop_req(0);
    mdl_last = 1'b0; exp_acks++;
  endtask

  task automatic test_ack_on_timeout();
    int port, cyc, bc; logic [31:0] rd, sa, sd; logic er, swe, own;
    slv_delay = MW - 1; slv_data = 32'h0000_1234;
    @(posedge clk); #1;
    set_req(0, 1'b0, 32'h0000_7F30, 32'h0);
    wait_ack(port, rd, er, cyc, bc, swe, sa, sd, own);
    checks++;
    if (port !== 0 || {er, rd} !== {1'b0, 32'h1234}) begin
      failures++; $display("FAIL ack_at_timeout got=port%0d err%b rd%h exp=port0 err0 rd00001234", port, er, rd);
    end
    checks++;
    if (bc !== MW) begin failures++; $display("FAIL ack_at_timeout_busy got=%0d exp=%0d", bc, MW); end
    drop_req(0);
    mdl_last = 1'b0; exp_acks++;
  endtask

  task automatic test_reset_mid();
    int port, cyc, bc, total; logic [31:0] rd, sa, sd; logic er, swe, own;
    slv_delay = -1;
    total = ack0_cnt + ack1_cnt;
    @(posedge clk); #1;
    set_req(0, 1'b1, 32'h0000_7F40, 32'hDEAD_BEEF);
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({s_req, busy, m0_ack, m1_ack} !== 4'b0) begin
      failures++; $display("FAIL rstmid_async got=%b exp=0000", {s_req, busy, m0_ack, m1_ack});
    end
    m0_req = 1'b0;
    mdl_last = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    checks++;
    if (ack0_cnt + ack1_cnt !== total) begin
      failures++; $display("FAIL rstmid_no_ack got=%0d exp=%0d", ack0_cnt + ack1_cnt, total);
    end
    slv_delay = 0; slv_data = 32'h0BAD_F00D;
    @(posedge clk); #1;
    set_req(1, 1'b0, 32'h0000_7F44, 32'h0);
    wait_ack(port, rd, er, cyc, bc, swe, sa, sd, own);
    checks++;
    if (port !== 1 || cyc !== 3 || {er, rd} !== {1'b0, 32'h0BAD_F00D}) begin
      failures++; $display("FAIL rstmid_after got=port%0d cyc%0d err%b rd%h exp=port1 cyc3 err0 rd0badf00d", port, cyc, er, rd);
    end
    drop_req(1);
    mdl_last = 1'b1; exp_acks++;
  endtask

  task automatic test_random();
    int port, cyc, bc, p, pat, pend, d; logic [31:0] rd, sa, sd, dat, exp_rd; logic er, swe, own, e_er;
    slv_noise = 1'b1;
    for (int it = 0; it < 30; it++) begin
      @(posedge clk); #1;
      pat = $urandom_range(1, 3);
      for (int q = 0; q < 2; q++) begin
        if (pat[q]) set_req(q, 1'($urandom_range(0, 1)), $urandom, $urandom);
      end
      pend = pat;
      while (pend != 0) begin
        p = (pend == 3) ? int'(!mdl_last) : (pend == 2 ? 1 : 0);
        d = $urandom_range(0, MW + 2);
        if (d == MW + 2) d = -1;
        dat = $urandom;
        slv_delay = d; slv_data = dat;
        wait_ack(port, rd, er, cyc, bc, swe, sa, sd, own);
        e_er   = exp_err(d);
        exp_rd = (rw[p] || e_er) ? 32'h0 : dat;
        checks++;
        if (port !== p || own !== p[0]) begin
          failures++; $display("FAIL rnd_grant it%0d got=port%0d own%b exp=%0d", it, port, own, p);
        end
        checks++;
        if ({swe, sa, sd} !== {rw[p], ra[p], rwd[p]}) begin
          failures++; $display("FAIL rnd_bus it%0d got=%b/%h/%h exp=%b/%h/%h", it, swe, sa, sd, rw[p], ra[p], rwd[p]);
        end
        checks++;
        if ({rd, er} !== {exp_rd, e_er}) begin
          failures++; $display("FAIL rnd_resp it%0d got=rd%h err%b exp=rd%h err%b", it, rd, er, exp_rd, e_er);
        end
        checks++;
        if (bc !== exp_busy(d) || cyc !== 2 + exp_busy(d)) begin
          failures++; $display("FAIL rnd_timing it%0d d%0d got=busy%0d cyc%0d exp=busy%0d", it, d, bc, cyc, exp_busy(d));
        end
        drop_req(p);
        mdl_last = p[0]; pend[p] = 1'b0; exp_acks++;
        if (port < 0) pend = 0;
      end
    end
    slv_noise = 1'b0;
  endtask

  task automatic test_ack_total();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (ack0_cnt + ack1_cnt !== exp_acks) begin
      failures++; $display("FAIL ack_total got=%0d exp=%0d", ack0_cnt + ack1_cnt, exp_acks);
    end
  endtask

  initial begin
    test_reset();
    test_write_m0();
    test_read_m1();
    test_round_robin();
    test_timeout();
    test_ack_on_timeout();
    test_reset_mid();
    test_random();
    test_ack_total();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
